// File: rtl/viterbi_decoder_pkg.sv
// Shared constants, FSM encoding and code helpers for the K=7 rate-1/2 hard-decision Viterbi decoder.
package viterbi_decoder_pkg;

  localparam int unsigned K          = 7;
  localparam int unsigned NUM_STATES = 64;
  localparam int unsigned STATE_W    = K - 1;
  localparam int unsigned ADDR_W     = 5;
  localparam int unsigned WORD_W     = 16;
  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned SURV_AW    = 8;
  localparam int unsigned ERR_W      = 16;

  // Generator taps over {u, s5..s0}
  localparam logic [K-1:0] G0 = 7'b1011011;
  localparam logic [K-1:0] G1 = 7'b1111001;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_FETCH,
    ST_ACS,
    ST_TB_SEL,
    ST_TRACE,
    ST_DONE
  } state_e;

  // Encoder output {c1, c0} when input u is shifted into encoder state s.
  function automatic logic [1:0] exp_out(input logic u, input logic [STATE_W-1:0] s);
    logic [K-1:0] reg_v;
    reg_v = {u, s};
    return {^(reg_v & G1), ^(reg_v & G0)};
  endfunction

  // Number of set bits in a 2-bit vector (branch metric of an XORed pair).
  function automatic logic [1:0] hamming2(input logic [1:0] x);
    return {x[1] & x[0], x[1] ^ x[0]};
  endfunction

endpackage

// File: rtl/viterbi_surv_ram.sv
// Simple dual-port survivor-bit RAM: one 64-bit word per trellis step, registered read.
module viterbi_surv_ram
  import viterbi_decoder_pkg::*;
(
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [SURV_AW-1:0]    waddr_i,
  input  logic [NUM_STATES-1:0] wdata_i,
  input  logic [SURV_AW-1:0]    raddr_i,
  output logic [NUM_STATES-1:0] rdata_o
);

  localparam int unsigned DEPTH = 1 << SURV_AW;

  logic [NUM_STATES-1:0] mem_q [DEPTH];
  logic [NUM_STATES-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/viterbi_decoder.sv
// Serial-ACS Viterbi decoder with best-state traceback into the received-data RAM.
// Optional VITERBI_ERRCNT_EN re-fetches words during traceback to count corrected channel bits.
module viterbi_decoder
  import viterbi_decoder_pkg::*;
#(
  parameter int unsigned NUM_WORDS = 15,
  parameter int unsigned PM_W      = 8,
  parameter int unsigned INIT_PM   = 63
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  output logic [ADDR_W-1:0] rd_addr_o,
  input  logic [WORD_W-1:0] rd_data_i,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [BYTE_W-1:0] dout_o,
  output logic              wea_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [ERR_W-1:0]  err_count_o
);

  localparam int unsigned        SUM_W     = PM_W + 1;
  localparam logic [SURV_AW-1:0] T_LAST    = SURV_AW'(8 * NUM_WORDS - 1);
  localparam logic [ADDR_W-1:0]  WORD_LAST = ADDR_W'(NUM_WORDS - 1);
  localparam logic [PM_W-1:0]    PM_START  = PM_W'(INIT_PM);
  localparam logic [STATE_W-1:0] J_LAST    = STATE_W'(NUM_STATES - 1);

  state_e                state_q, state_d;
  logic                  start_q;
  logic                  ph_q, ph_d;
  logic [STATE_W-1:0]    j_q, j_d;
  logic [2:0]            k_q, k_d;
  logic [ADDR_W-1:0]     word_q, word_d;
  logic                  bank_q, bank_d;
  logic [PM_W-1:0]       min_prev_q, min_prev_d;
  logic [PM_W-1:0]       min_run_q, min_run_d;
  logic [STATE_W-1:0]    argmin_q, argmin_d;
  logic [NUM_STATES-1:0] surv_vec_q, surv_vec_d;
  logic [WORD_W-1:0]     wbuf_q, wbuf_d;
  logic [SURV_AW-1:0]    t_q, t_d;
  logic [STATE_W-1:0]    s_q, s_d;
  logic [BYTE_W-1:0]     byte_q, byte_d;
  logic [ADDR_W-1:0]     rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0]     wr_addr_q, wr_addr_d;
  logic [BYTE_W-1:0]     dout_q, dout_d;
  logic                  wea_q, wea_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic [PM_W-1:0]       pm_q [2][NUM_STATES];

  logic [STATE_W-1:0]    p0_c, p1_c, prev_c;
  logic [1:0]            rx_c, bm0_c, bm1_c;
  logic [SUM_W-1:0]      sum0_c, sum1_c, best_c, norm_c;
  logic [PM_W-1:0]       new_pm_c;
  logic                  sel_c, tb_bit_c;
  logic                  pm_init_c, pm_we_c, surv_we_c;
  logic [NUM_STATES-1:0] surv_rdata_c;

`ifdef VITERBI_ERRCNT_EN
  logic [ERR_W-1:0]      err_q, err_d;
  logic                  tracing_q, tracing_d;
  logic [1:0]            rx_tb_c, errs_c;
  logic [ERR_W:0]        err_sum_c;
`endif

  // Add-compare-select for next state j_q; predecessors share j[4:0] and differ in the LSB.
  assign p0_c     = {j_q[STATE_W-2:0], 1'b0};
  assign p1_c     = {j_q[STATE_W-2:0], 1'b1};
  assign rx_c     = wbuf_q[{k_q, 1'b0} +: 2];
  assign bm0_c    = hamming2(exp_out(j_q[STATE_W-1], p0_c) ^ rx_c);
  assign bm1_c    = hamming2(exp_out(j_q[STATE_W-1], p1_c) ^ rx_c);
  assign sum0_c   = {1'b0, pm_q[bank_q][p0_c]} + SUM_W'(bm0_c);
  assign sum1_c   = {1'b0, pm_q[bank_q][p1_c]} + SUM_W'(bm1_c);
  assign sel_c    = (sum1_c < sum0_c);
  assign best_c   = sel_c ? sum1_c : sum0_c;
  assign norm_c   = best_c - {1'b0, min_prev_q};
  assign new_pm_c = norm_c[PM_W] ? {PM_W{1'b1}} : norm_c[PM_W-1:0];

  assign tb_bit_c = surv_rdata_c[s_q];
  assign prev_c   = {s_q[STATE_W-2:0], tb_bit_c};

`ifdef VITERBI_ERRCNT_EN
  assign rx_tb_c   = wbuf_q[{t_q[2:0], 1'b0} +: 2];
  assign errs_c    = hamming2(exp_out(s_q[STATE_W-1], prev_c) ^ rx_tb_c);
  assign err_sum_c = {1'b0, err_q} + (ERR_W + 1)'(errs_c);
`endif

  viterbi_surv_ram u_surv_ram (
    .clk     (clk),
    .we_i    (surv_we_c),
    .waddr_i ({word_q, k_q}),
    .wdata_i (surv_vec_d),
    .raddr_i (t_q),
    .rdata_o (surv_rdata_c)
  );

  always_comb begin
    state_d    = state_q;
    ph_d       = ph_q;
    j_d        = j_q;
    k_d        = k_q;
    word_d     = word_q;
    bank_d     = bank_q;
    min_prev_d = min_prev_q;
    min_run_d  = min_run_q;
    argmin_d   = argmin_q;
    surv_vec_d = surv_vec_q;
    wbuf_d     = wbuf_q;
    t_d        = t_q;
    s_d        = s_q;
    byte_d     = byte_q;
    rd_addr_d  = rd_addr_q;
    wr_addr_d  = wr_addr_q;
    dout_d     = dout_q;
    wea_d      = 1'b0;
    pm_init_c  = 1'b0;
    pm_we_c    = 1'b0;
    surv_we_c  = 1'b0;
`ifdef VITERBI_ERRCNT_EN
    err_d      = err_q;
    tracing_d  = tracing_q;
`endif

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_i && !start_q) state_d = ST_INIT;
      end

      ST_INIT: begin
        pm_init_c  = 1'b1;
        bank_d     = 1'b0;
        min_prev_d = '0;
        word_d     = '0;
        j_d        = '0;
        k_d        = '0;
        ph_d       = 1'b0;
        rd_addr_d  = '0;
        state_d    = ST_FETCH;
`ifdef VITERBI_ERRCNT_EN
        err_d      = '0;
        tracing_d  = 1'b0;
`endif
      end

      // rd_addr is already valid on entry; the RAM answers in the second cycle.
      ST_FETCH: begin
        ph_d = ~ph_q;
        if (ph_q) begin
          wbuf_d  = rd_data_i;
          state_d = ST_ACS;
`ifdef VITERBI_ERRCNT_EN
          if (tracing_q) state_d = ST_TRACE;
`endif
        end
      end

      ST_ACS: begin
        pm_we_c         = 1'b1;
        surv_vec_d[j_q] = sel_c;
        if ((j_q == '0) || (new_pm_c < min_run_q)) begin
          min_run_d = new_pm_c;
          argmin_d  = j_q;
        end
        j_d = j_q + 1'b1;
        if (j_q == J_LAST) begin
          surv_we_c  = 1'b1;
          bank_d     = ~bank_q;
          min_prev_d = min_run_d;
          k_d        = k_q + 1'b1;
          if (k_q == 3'd7) begin
            if (word_q == WORD_LAST) begin
              state_d = ST_TB_SEL;
            end else begin
              word_d    = word_q + 1'b1;
              rd_addr_d = word_q + 1'b1;
              state_d   = ST_FETCH;
            end
          end
        end
      end

      ST_TB_SEL: begin
        s_d     = argmin_q;
        t_d     = T_LAST;
        ph_d    = 1'b0;
        state_d = ST_TRACE;
`ifdef VITERBI_ERRCNT_EN
        rd_addr_d = WORD_LAST;
        tracing_d = 1'b1;
        state_d   = ST_FETCH;
`endif
      end

      // Phase 0 addresses surv[t]; phase 1 consumes the survivor bit.
      ST_TRACE: begin
        ph_d = ~ph_q;
        if (ph_q) begin
          byte_d[t_q[2:0]] = s_q[STATE_W-1];
          s_d              = prev_c;
`ifdef VITERBI_ERRCNT_EN
          err_d = err_sum_c[ERR_W] ? {ERR_W{1'b1}} : err_sum_c[ERR_W-1:0];
`endif
          if (t_q[2:0] == 3'd0) begin
            wea_d     = 1'b1;
            wr_addr_d = t_q[SURV_AW-1:3];
            dout_d    = byte_d;
          end
          if (t_q == '0) begin
            state_d = ST_DONE;
          end else begin
            t_d = t_q - 1'b1;
`ifdef VITERBI_ERRCNT_EN
            if (t_q[2:0] == 3'd0) begin
              rd_addr_d = t_q[SURV_AW-1:3] - 1'b1;
              state_d   = ST_FETCH;
            end
`endif
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE) && (state_d != ST_DONE);
    done_d = (state_d == ST_DONE);
  end

  // Start edge detector samples through reset so a level held across reset cannot fire.
  always_ff @(posedge clk) begin
    start_q <= start_i;
  end

  always_ff @(posedge clk) begin
    if (pm_init_c) begin
      for (int i = 0; i < NUM_STATES; i++) begin
        pm_q[0][i] <= (i == 0) ? '0 : PM_START;
      end
    end else if (pm_we_c) begin
      pm_q[~bank_q][j_q] <= new_pm_c;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ph_q       <= 1'b0;
      j_q        <= '0;
      k_q        <= '0;
      word_q     <= '0;
      bank_q     <= 1'b0;
      min_prev_q <= '0;
      min_run_q  <= '0;
      argmin_q   <= '0;
      surv_vec_q <= '0;
      wbuf_q     <= '0;
      t_q        <= '0;
      s_q        <= '0;
      byte_q     <= '0;
      rd_addr_q  <= '0;
      wr_addr_q  <= '0;
      dout_q     <= '0;
      wea_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ph_q       <= ph_d;
      j_q        <= j_d;
      k_q        <= k_d;
      word_q     <= word_d;
      bank_q     <= bank_d;
      min_prev_q <= min_prev_d;
      min_run_q  <= min_run_d;
      argmin_q   <= argmin_d;
      surv_vec_q <= surv_vec_d;
      wbuf_q     <= wbuf_d;
      t_q        <= t_d;
      s_q        <= s_d;
      byte_q     <= byte_d;
      rd_addr_q  <= rd_addr_d;
      wr_addr_q  <= wr_addr_d;
      dout_q     <= dout_d;
      wea_q      <= wea_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

`ifdef VITERBI_ERRCNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q     <= '0;
      tracing_q <= 1'b0;
    end else begin
      err_q     <= err_d;
      tracing_q <= tracing_d;
    end
  end

  assign err_count_o = err_q;
`else
  assign err_count_o = '0;
`endif

  assign rd_addr_o = rd_addr_q;
  assign wr_addr_o = wr_addr_q;
  assign dout_o    = dout_q;
  assign wea_o     = wea_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;

endmodule

// File: tb/tb_viterbi_decoder.sv
// Self-checking bench: reference convolutional encoder plus channel flips; decoded bytes must equal the payload.
module tb_viterbi_decoder;

  localparam int unsigned NW = 15;
`ifdef VITERBI_ERRCNT_EN
  localparam int unsigned ERRCNT = 1;
`else
  localparam int unsigned ERRCNT = 0;
`endif
  localparam int unsigned EXP_LAT = 7953 + 2 * NW * ERRCNT;
  localparam int unsigned LIMIT   = 12000;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [4:0]  rd_addr_o;
  logic [15:0] rd_data_i;
  logic [4:0]  wr_addr_o;
  logic [7:0]  dout_o;
  logic        wea_o;
  logic        busy_o;
  logic        done_o;
  logic [15:0] err_count_o;

  logic [15:0] enc_mem [32];
  logic [7:0]  payload [32];
  logic [7:0]  out_mem [32];

  int n_checks = 0;
  int n_pass   = 0;
  int wea_cnt  = 0;
  int exp_addr = 0;
  bit mon_en   = 1'b0;

  always #5 clk = ~clk;

  viterbi_decoder dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .rd_addr_o   (rd_addr_o),
    .rd_data_i   (rd_data_i),
    .wr_addr_o   (wr_addr_o),
    .dout_o      (dout_o),
    .wea_o       (wea_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_count_o (err_count_o)
  );

  // Encoded-bits RAM: synchronous read, one cycle latency.
  always @(posedge clk) rd_data_i <= enc_mem[rd_addr_o];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Every write strobe: addresses must descend from NW-1 and each byte must match the payload.
  always @(negedge clk) begin
    if (wea_o) begin
      wea_cnt++;
      out_mem[wr_addr_o] = dout_o;
      if (mon_en) begin
        check("wr_addr_order", 32'(wr_addr_o), 32'(exp_addr));
        check("dout_stream", 32'(dout_o), 32'(payload[wr_addr_o]));
        exp_addr--;
      end
    end
  end

  // Reference encoder straight from the code definition; state carries across words.
  task automatic encode_payload();
    logic [5:0] st;
    logic       u, c0, c1;
    st = '0;
    for (int w = 0; w < 32; w++) enc_mem[w] = '0;
    for (int w = 0; w < NW; w++) begin
      for (int k = 0; k < 8; k++) begin
        u  = payload[w][k];
        c0 = u ^ st[4] ^ st[3] ^ st[1] ^ st[0];
        c1 = u ^ st[5] ^ st[4] ^ st[3] ^ st[0];
        enc_mem[w][2*k]   = c0;
        enc_mem[w][2*k+1] = c1;
        st = {u, st[5:1]};
      end
    end
  endtask

  task automatic flip(input int pos);
    enc_mem[pos / 16][pos % 16] = ~enc_mem[pos / 16][pos % 16];
  endtask

  task automatic run_frame(input string tag, input int exp_err);
    int cyc;
    for (int i = 0; i < 32; i++) out_mem[i] = ~payload[i];
    wea_cnt  = 0;
    exp_addr = NW - 1;
    mon_en   = 1'b1;
    start_i  = 1'b0;
    @(posedge clk); #1;
    start_i = 1'b1;
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1) begin
        check($sformatf("%s_busy_on_start", tag), 32'(busy_o), 32'd1);
        check($sformatf("%s_done_cleared", tag), 32'(done_o), 32'd0);
      end
    end while (!done_o && cyc < LIMIT);
    @(negedge clk); #1;
    check($sformatf("%s_latency", tag), 32'(cyc), 32'(EXP_LAT));
    check($sformatf("%s_wea_count", tag), 32'(wea_cnt), 32'(NW));
    check($sformatf("%s_busy_at_done", tag), 32'(busy_o), 32'd0);
    check($sformatf("%s_err_count", tag), 32'(err_count_o), 32'(exp_err));
    for (int i = 0; i < NW; i++)
      check($sformatf("%s_byte%0d", tag, i), 32'(out_mem[i]), 32'(payload[i]));
    mon_en = 1'b0;
  endtask

  initial begin
    int p1, p2;
    rst     = 1'b1;
    start_i = 1'b0;
    for (int i = 0; i < 32; i++) begin
      payload[i] = '0;
      enc_mem[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    check("rst_rd_addr", 32'(rd_addr_o), 32'd0);
    check("rst_wr_addr", 32'(wr_addr_o), 32'd0);
    check("rst_dout", 32'(dout_o), 32'd0);
    check("rst_wea", 32'(wea_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_err_count", 32'(err_count_o), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Impulse: a single 1 in data bit 0 of byte 0
    payload[0] = 8'h01;
    encode_payload();
    check("enc_pin_w0", 32'(enc_mem[0]), 32'h34FB);
    check("enc_pin_w1", 32'(enc_mem[1]), 32'h0000);
    run_frame("impulse", 0);

    // Start left high after completion must not restart the decoder
    repeat (50) @(posedge clk);
    #1;
    check("held_start_busy", 32'(busy_o), 32'd0);
    check("held_start_done", 32'(done_o), 32'd1);

    for (int i = 0; i < 32; i++) payload[i] = '0;
    encode_payload();
    run_frame("zeros", 0);

    payload[0] = 8'h01;
    encode_payload();
    flip(0);
    check("enc_pin_flip", 32'(enc_mem[0]), 32'h34FA);
    run_frame("single_flip", int'(ERRCNT));

    // Random payloads with two well-separated channel errors away from the unterminated tail
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < NW; i++) payload[i] = 8'($urandom);
      encode_payload();
      p1 = int'($urandom_range(0, 79));
      p2 = p1 + 12 + int'($urandom_range(0, 80));
      flip(p1);
      flip(p2);
      run_frame($sformatf("rand%0d", r), int'(2 * ERRCNT));
    end

    // Reset in the middle of a frame
    for (int i = 0; i < NW; i++) payload[i] = 8'($urandom);
    encode_payload();
    start_i = 1'b0;
    @(posedge clk); #1;
    start_i = 1'b1;
    repeat (3000) @(posedge clk);
    #1;
    check("midframe_busy", 32'(busy_o), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("post_rst_busy", 32'(busy_o), 32'd0);
    check("post_rst_done", 32'(done_o), 32'd0);
    check("post_rst_wea", 32'(wea_o), 32'd0);
    wea_cnt = 0;
    repeat (200) @(posedge clk);
    #1;
    check("post_rst_no_writes", 32'(wea_cnt), 32'd0);
    check("post_rst_stays_idle", 32'(busy_o), 32'd0);
    run_frame("after_rst", 0);

    // Low-then-high start decodes the same frame again identically
    repeat (20) @(posedge clk);
    #1;
    run_frame("rerun", 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
